result_tx_fifo: RTL
===================

# result_tx_fifo

Result buffer between the ALU interface block and the UART transmitter. It captures every result byte the interface emits (one-cycle valid pulse), queues it in a circular FIFO, and feeds the transmitter one byte at a time, waiting for the transmitter's done tick before launching the next. Burst results are therefore never lost while the serial line is still busy.

## Interface
- `NB_DATA`, default 8: data byte width.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `i_clock`, in, 1: system clock; all state updates on rising edge.
- `i_reset`, in, 1: asynchronous reset, active-low. Single clock domain.
- `i_valid`, in, 1: push strobe from the interface result valid; one byte per high cycle.
- `i_data`, in, NB_DATA: result byte; sampled when `i_valid`=1.
- `i_tx_done_tick`, in, 1: one-cycle pulse from the UART transmitter at end of stop bit.
- `o_tx_start`, out, 1: one-cycle start pulse to the transmitter ready input.
- `o_tx_data`, out, NB_DATA: byte to the transmitter data input. Equals FIFO head; stable from `o_tx_start` until the matching done tick.
- `o_empty`, out, 1: level == 0.
- `o_full`, out, 1: level == 2^DEPTH_LOG2.
- `o_level`, out, DEPTH_LOG2+1: current occupancy.
- `o_overflow`, out, 1: present only with `RESULT_TX_FIFO_OVF_EN`.

## Operation
- Storage: 2^DEPTH_LOG2 × NB_DATA register array.
  - Write and read pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Level counter is DEPTH_LOG2+1 bits.
- Push: `i_valid`=1 and (not full, or a pop occurs in the same cycle).
  - Write `i_data` at wr_ptr, increment wr_ptr.
  - Push while full with no simultaneous pop: byte dropped, pointers and level unchanged.
- Pop: `i_tx_done_tick`=1 while state is BUSY. Increment rd_ptr.
- Level update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Drain FSM, two states:
  - IDLE: if level ≠ 0, go to BUSY and register `o_tx_start`=1 for exactly one cycle.
  - BUSY: hold `o_tx_data`. On `i_tx_done_tick`, pop and return to IDLE.
- `i_tx_done_tick` received in IDLE is ignored: no pop, no state change.
- `o_tx_data` = mem[rd_ptr], combinational from registered pointer. When empty it shows stale contents, which are don't-care.
- Reset (asynchronous, any time, including mid-frame):
  - pointers 0, level 0, state IDLE.
  - `o_tx_start`=0, `o_empty`=1, `o_full`=0, `o_level`=0, `o_overflow`=0.
  - Memory contents are not cleared.
  - A done tick from a frame that was in flight at reset arrives in IDLE and is ignored.

## Timing
- Push at edge k: `o_level`, `o_empty` and `o_full` reflect it after edge k.
- First-byte latency: `i_valid` sampled at edge k → `o_tx_start` high during the cycle after edge k+1 (2 cycles).
- Back-to-back:
  - done tick sampled at edge j → IDLE after j.
  - If level ≠ 0 after j, `o_tx_start` high after edge j+1.
  - Minimum 2 cycles from done tick to next start.
- `o_tx_start` is never high on two consecutive cycles.
- Exactly one `o_tx_start` per popped byte.
- Throughput is bounded by the UART frame time. The FIFO adds no more than 2 cycles per byte.

## Configuration
- `RESULT_TX_FIFO_OVF_EN` defined:
  - adds output `o_overflow`, 1 bit.
  - Set on the edge after a dropped push. Sticky until reset.
- Not defined:
  - port absent.
  - Drops are silent. All other behaviour is identical.

## Test plan
- Single byte: reset, push 0xA5 → `o_tx_start` pulses 2 cycles later with `o_tx_data`=0xA5. `o_level`=1 until the done tick, then 0 and `o_empty`=1.
- Burst order: push 0x01,0x02,0x03 on consecutive cycles, done tick 20 cycles after each start → three starts carrying 0x01, 0x02, 0x03 in order, each ≥2 cycles after the previous done tick.
- Full/overflow:
  - push 17 bytes 0x00..0x10 with no done ticks → `o_full`=1 and `o_level`=16. 0x10 is dropped.
  - With the macro, `o_overflow`=1. Draining yields 0x00..0x0F.
- Simultaneous: with FIFO full and BUSY, assert `i_valid` (0x77) and `i_tx_done_tick` in the same cycle → level stays 16. 0x77 is later transmitted last. `o_overflow` stays 0.
- Wrap-around: 40 push/pop pairs with varying gaps → output sequence equals input sequence across pointer wrap, no duplicates or losses.
- Reset mid-operation:
  - with 5 bytes queued and BUSY, pull `i_reset` low asynchronously → all outputs reset immediately.
  - After release, a stray done tick causes no start. A new push 0x3C is sent as the first byte.

Source files
------------

// File: rtl/result_tx_fifo.sv
// result_tx_fifo
// Circular byte FIFO between the ALU interface result strobe and the UART
// transmitter. Bytes are pushed on i_valid and released one at a time: a
// one-cycle o_tx_start launches the head byte, and the transmitter's done
// tick pops it before the next byte is launched.
// Optional feature: define RESULT_TX_FIFO_OVF_EN to add a sticky o_overflow
// flag that records any push dropped because the FIFO was full.
//
// state  | meaning
// IDLE   | no byte in flight; launch head byte as soon as level != 0
// BUSY   | head byte handed to transmitter; waiting for its done tick
module result_tx_fifo #(
  parameter int NB_DATA    = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [NB_DATA-1:0]    i_data,
  input  logic                  i_tx_done_tick,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level
`ifdef RESULT_TX_FIFO_OVF_EN
  ,
  output logic                  o_overflow
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  logic [NB_DATA-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  state_t                state;
  logic                  full;
  logic                  pop;
  logic                  push;

  assign full = (level == LEVEL_FULL);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted when the transmitter is finishing a byte.
  assign pop  = i_tx_done_tick && (state == S_BUSY);
  assign push = i_valid && (!full || pop);

  // Storage write; memory is deliberately not reset.
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Drain FSM with a registered single-cycle start pulse.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      o_tx_start <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (level != '0) begin
            state      <= S_BUSY;
            o_tx_start <= 1'b1;
          end
        end
        S_BUSY: begin
          if (i_tx_done_tick) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RESULT_TX_FIFO_OVF_EN
  // Sticky record of any byte dropped because the FIFO was full.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_overflow <= 1'b0;
    end else if (i_valid && !push) begin
      o_overflow <= 1'b1;
    end
  end
`endif

  assign o_tx_data = mem[rd_ptr];
  assign o_empty   = (level == '0);
  assign o_full    = full;
  assign o_level   = level;

endmodule
